// File: rtl/systolic_sequencer.sv
// systolic_sequencer
//
// Command-driven controller for the NxN systolic matrix-multiply datapath.
// It accepts a matmul command that covers a number of K-tiles. For each tile
// it requests an operand load, then holds the diagonal feeder enable for one
// feed window. It manages the accumulator clear and enable, waits for the
// array to drain, and presents the result with a valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where both sides are high.
//   cmd_valid/cmd_ready : the command is taken in an IDLE cycle.
//   load_req/load_ack   : the tile is resident once load_ack is sampled in LOAD.
//   out_valid/out_ready : the result is consumed once out_ready is sampled in RESULT.
// Every output is decoded from registered state, so no input reaches an
// output combinationally.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_tiles, cmd_clear tile count and accumulator-clear flag, captured on accept
//   load_req/load_ack    tile load handshake
//   feed_en              feeder enable; a low level restarts the feeder at step 0
//   acc_clear, acc_en    accumulator clear pulse and capture enable
//   tile_idx             index of the tile being loaded or fed
//   out_valid/out_ready  result handshake
//   busy, done           not-idle flag and one-cycle completion pulse
//   dbg_state            current FSM state, for observation only
module systolic_sequencer #(
    parameter int N            = 32,
    parameter int FEED_CYCLES  = 2 * N - 1,
    parameter int DRAIN_CYCLES = N,
    parameter int TW           = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [TW-1:0] cmd_tiles,
    input  logic          cmd_clear,
    output logic          load_req,
    input  logic          load_ack,
    output logic          feed_en,
    output logic          acc_clear,
    output logic          acc_en,
    output logic [TW-1:0] tile_idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [2:0]    dbg_state
);

    localparam int CNT_MAX = (FEED_CYCLES > DRAIN_CYCLES) ? FEED_CYCLES : DRAIN_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] FEED_LAST  = CW'(FEED_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_LOAD   = 3'd2,
        S_FEED   = 3'd3,
        S_DRAIN  = 3'd4,
        S_RESULT = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tile_q, tile_d;
    logic [TW-1:0] tiles_q, tiles_d;
    logic          last_tile;

    // The sum is widened by one bit, so tile_idx+1 cannot wrap when tiles = 2^TW-1.
    assign last_tile = ({1'b0, tile_q} + (TW+1)'(1)) >= {1'b0, tiles_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tile_q  <= '0;
            tiles_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tile_q  <= tile_d;
            tiles_q <= tiles_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tile_d  = tile_q;
        tiles_d = tiles_q;
        case (state_q)
            S_IDLE: begin
                tile_d = '0;
                cnt_d  = '0;
                if (cmd_valid) begin
                    tiles_d = cmd_tiles;
                    if (cmd_tiles == '0) begin
                        state_d = S_DONE;
                    end else if (cmd_clear) begin
                        state_d = S_CLR;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_CLR: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (load_ack) begin
                    state_d = S_FEED;
                    cnt_d   = '0;
                end
            end
            S_FEED: begin
                if (cnt_q == FEED_LAST) begin
                    cnt_d = '0;
                    if (last_tile) begin
                        state_d = S_DRAIN;
                    end else begin
                        tile_d  = tile_q + TW'(1);
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RESULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESULT: begin
                if (out_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                tile_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        acc_clear = 1'b0;
        load_req  = 1'b0;
        feed_en   = 1'b0;
        acc_en    = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE:   cmd_ready = 1'b1;
            S_CLR:    acc_clear = 1'b1;
            S_LOAD:   load_req  = 1'b1;
            S_FEED: begin
                feed_en = 1'b1;
                acc_en  = 1'b1;
            end
            S_DRAIN:  acc_en    = 1'b1;
            S_RESULT: out_valid = 1'b1;
            S_DONE:   done      = 1'b1;
            default: begin
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign tile_idx  = tile_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Testbench for systolic_sequencer.
//
// The model builds the full expected output timeline of each command as a
// list of per-cycle output words. It works from the phase lengths: accept,
// optional clear, (load + feed window) per tile, drain, result, and done.
// A compare process pops one word at every falling edge and checks it.
module tb_systolic_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_tiles;
    logic       cmd_clear;
    logic       load_req;
    logic       load_ack;
    logic       feed_en;
    logic       acc_clear;
    logic       acc_en;
    logic [7:0] tile_idx;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;

    systolic_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_tiles (cmd_tiles),
        .cmd_clear (cmd_clear),
        .load_req  (load_req),
        .load_ack  (load_ack),
        .feed_en   (feed_en),
        .acc_clear (acc_clear),
        .acc_en    (acc_en),
        .tile_idx  (tile_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    localparam int FEED  = 63;
    localparam int DRAIN = 32;

    // Output word: {cmd_ready, acc_clear, load_req, feed_en, acc_en, out_valid, done, busy, tile_idx}
    logic [15:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    int ack_delay = 0;
    int rdy_delay = 0;
    int lcnt = 0;
    int rcnt = 0;

    // Observation counters used for the literal checks.
    int feed_windows = 0;
    int done_cnt = 0;
    int clr_cnt = 0;
    int load_cycles = 0;
    int max_idx = 0;
    logic feed_prev = 1'b0;

    function automatic logic [15:0] ent(bit rdy, bit clr, bit ld, bit fe, bit ae,
                                        bit ov, bit dn, bit bz, int idx);
        return {rdy, clr, ld, fe, ae, ov, dn, bz, 8'(idx)};
    endfunction

    function automatic logic [15:0] idle_e();
        return ent(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Expected timeline of one command, starting at its accept cycle.
    function automatic void push_cmd(int tiles, bit clr, int ad, int rd);
        exp_q.push_back(idle_e());
        if (tiles == 0) begin
            exp_q.push_back(ent(0, 0, 0, 0, 0, 0, 1, 1, 0));
            return;
        end
        if (clr) exp_q.push_back(ent(0, 1, 0, 0, 0, 0, 0, 1, 0));
        for (int t = 0; t < tiles; t++) begin
            for (int i = 0; i <= ad; i++) exp_q.push_back(ent(0, 0, 1, 0, 0, 0, 0, 1, t));
            for (int i = 0; i < FEED; i++) exp_q.push_back(ent(0, 0, 0, 1, 1, 0, 0, 1, t));
        end
        for (int i = 0; i < DRAIN; i++) exp_q.push_back(ent(0, 0, 0, 0, 1, 0, 0, 1, tiles - 1));
        for (int i = 0; i <= rd; i++) exp_q.push_back(ent(0, 0, 0, 0, 0, 1, 0, 1, tiles - 1));
        exp_q.push_back(ent(0, 0, 0, 0, 0, 0, 1, 1, tiles - 1));
    endfunction

    function automatic int first_with(int b);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][b]) return i;
        end
        return -1;
    endfunction

    function automatic int count_with(int b);
        int n = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][b]) n++;
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        feed_windows = 0;
        done_cnt = 0;
        clr_cnt = 0;
        load_cycles = 0;
        max_idx = 0;
    endtask

    // Load/result responders: with a delay of 0 the input is tied high (and
    // must be ignored outside its state); otherwise it rises after the delay.
    always @(negedge clk) begin
        if (ack_delay == 0) begin
            load_ack = 1'b1;
            lcnt = 0;
        end else if (load_req === 1'b1) begin
            load_ack = (lcnt >= ack_delay);
            lcnt++;
        end else begin
            load_ack = 1'b0;
            lcnt = 0;
        end
        if (rdy_delay == 0) begin
            out_ready = 1'b1;
            rcnt = 0;
        end else if (out_valid === 1'b1) begin
            out_ready = (rcnt >= rdy_delay);
            rcnt++;
        end else begin
            out_ready = 1'b0;
            rcnt = 0;
        end
    end

    // Compare process and observation counters.
    always @(negedge clk) begin
        logic [15:0] exp_w;
        logic [15:0] act_w;
        act_w = {cmd_ready, acc_clear, load_req, feed_en, acc_en, out_valid, done, busy, tile_idx};
        if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            checks++;
            if (act_w !== exp_w) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t act=%h exp=%h", $time, act_w, exp_w);
            end
        end
        if (feed_en === 1'b1 && feed_prev !== 1'b1) feed_windows++;
        if (done === 1'b1) done_cnt++;
        if (acc_clear === 1'b1) clr_cnt++;
        if (load_req === 1'b1) load_cycles++;
        if (busy === 1'b1 && int'(tile_idx) > max_idx) max_idx = int'(tile_idx);
        feed_prev = feed_en;
    end

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout remaining=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_cmd(input int tiles, input bit clr, input int ad, input int rd);
        @(posedge clk);
        #1;
        ack_delay = ad;
        rdy_delay = rd;
        cmd_tiles = 8'(tiles);
        cmd_clear = clr;
        cmd_valid = 1'b1;
        push_cmd(tiles, clr, ad, rd);
        exp_q.push_back(idle_e());
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_drain(tiles * 80 + 400);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_tiles = '0;
        cmd_clear = 1'b0;
        load_ack = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(idle_e());
        exp_q.push_back(idle_e());
        wait_drain(10);

        // Pin the model against hand-computed timing for tiles=1.
        push_cmd(1, 0, 0, 0);
        chk("model_first_feed", first_with(12), 2);
        chk("model_feed_len", count_with(12), 63);
        chk("model_acc_en_len", count_with(11), 95);
        chk("model_out_valid", first_with(10), 97);
        chk("model_done", first_with(9), 98);
        chk("model_len", exp_q.size(), 99);
        exp_q.delete();
        push_cmd(0, 0, 0, 0);
        chk("model_t0_done", first_with(9), 1);
        exp_q.delete();

        // Single tile, no clear.
        clear_mon();
        run_cmd(1, 0, 0, 0);
        chk("t1_windows", feed_windows, 1);
        chk("t1_done", done_cnt, 1);

        // Three tiles, clear, delayed load acknowledge.
        clear_mon();
        run_cmd(3, 1, 4, 0);
        chk("t3_clear_pulses", clr_cnt, 1);
        chk("t3_windows", feed_windows, 3);
        chk("t3_load_cycles", load_cycles, 15);
        chk("t3_max_idx", max_idx, 2);

        // Zero tiles.
        clear_mon();
        run_cmd(0, 0, 0, 0);
        chk("t0_windows", feed_windows, 0);
        chk("t0_loads", load_cycles, 0);
        chk("t0_done", done_cnt, 1);

        // Result stall with cmd_valid held: the second command (tiles=0) is
        // taken in the IDLE cycle right after done.
        clear_mon();
        @(posedge clk);
        #1;
        ack_delay = 0;
        rdy_delay = 10;
        cmd_tiles = 8'd1;
        cmd_clear = 1'b0;
        cmd_valid = 1'b1;
        push_cmd(1, 0, 0, 10);
        chk("model_stall_ov", count_with(10), 11);
        push_cmd(0, 0, 0, 0);
        exp_q.push_back(idle_e());
        @(posedge clk);
        #1;
        cmd_tiles = 8'd0;
        repeat (109) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_drain(300);
        chk("stall_done", done_cnt, 2);

        // Reset in the middle of the feed window (cycle 30).
        clear_mon();
        @(posedge clk);
        #1;
        ack_delay = 0;
        rdy_delay = 0;
        cmd_tiles = 8'd1;
        cmd_valid = 1'b1;
        exp_q.push_back(idle_e());
        exp_q.push_back(ent(0, 0, 1, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 29; i++) exp_q.push_back(ent(0, 0, 0, 1, 1, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++) exp_q.push_back(idle_e());
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_drain(20);
        chk("rst_no_done", done_cnt, 0);
        run_cmd(1, 0, 0, 0);
        chk("post_rst_done", done_cnt, 1);

        // Maximum tile count.
        clear_mon();
        run_cmd(255, 0, 0, 0);
        chk("t255_windows", feed_windows, 255);
        chk("t255_max_idx", max_idx, 254);
        chk("t255_done", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Command-driven controller for the 32x32 systolic matrix-multiply datapath. It accepts a matmul command covering a number of K-tiles, sequences tile loads, and holds the skewed-diagonal feeder enable (`feed_en`) high for exactly one feed window per tile. It manages accumulator clear/enable, waits for the array to drain, and then presents a result-valid handshake. It sits between the host command interface and the feeder, buffer and accumulator blocks.

## Interface
- `N`, 32: systolic array dimension.
- `FEED_CYCLES`, 2*N-1 (63): cycles `feed_en` stays high per tile; one diagonal per cycle.
- `DRAIN_CYCLES`, N (32): cycles after the last feed before results are valid.
- `TW`, 8: width of the tile count and tile index.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_tiles`  in  TW  number of K-tiles to accumulate; captured on handshake.
- `cmd_clear`  in  1  clear accumulators before the first tile; captured on handshake.
- `load_req`  out  1  request the next tile in the operand buffers.
- `load_ack`  in  1  requested tile is resident.
- `feed_en`  out  1  enable to the diagonal feeder; a low level resets the feeder's step counter.
- `acc_clear`  out  1  one-cycle accumulator clear pulse.
- `acc_en`  out  1  accumulators capture array outputs.
- `tile_idx`  out  TW  index of the tile being loaded or fed.
- `out_valid`  out  1  accumulated result is stable.
- `out_ready`  in  1  consumer takes the result.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States and their outputs:
  - IDLE: `cmd_ready`=1.
  - CLR: `acc_clear`=1.
  - LOAD: `load_req`=1.
  - FEED: `feed_en`=1, `acc_en`=1.
  - DRAIN: `acc_en`=1.
  - RESULT: `out_valid`=1.
  - DONE: `done`=1.
- All other outputs are 0 in each state. Every output is decoded from registered state/counters; no combinational input-to-output paths.
- State transitions:
  - IDLE, on `cmd_valid`&&`cmd_ready`: latch `cmd_tiles`/`cmd_clear`. If tiles==0, go to DONE with no load/feed/acc activity. Else if clear, go to CLR. Else go to LOAD.
  - CLR -> LOAD unconditionally (exactly one cycle).
  - LOAD: hold `load_req` until `load_ack` is sampled high, then go to FEED with the cycle counter at 0. `load_ack` outside LOAD is ignored.
  - FEED: counter increments every cycle. At counter==FEED_CYCLES-1:
    - if `tile_idx`+1 < tiles: increment `tile_idx` and go to LOAD;
    - otherwise go to DRAIN with the counter at 0.
  - DRAIN: at counter==DRAIN_CYCLES-1, go to RESULT.
  - RESULT: hold `out_valid` until `out_ready` is sampled high, then go to DONE.
  - DONE -> IDLE unconditionally.
- `tile_idx`: 0 in IDLE and during the first tile; never exceeds tiles-1; cleared on entry to IDLE.
- Counter width: $clog2(max(FEED_CYCLES, DRAIN_CYCLES)). It never wraps; it is reset to 0 on every entry to FEED and DRAIN.
- `cmd_tiles`=2^TW-1 (255) is legal: 255 feed windows, single drain.
- Commands presented while busy are not accepted (`cmd_ready`=0). `cmd_valid` may stay high; it is taken in the first IDLE cycle.

## Timing
- Reset: takes effect at the first clock edge with `rst`=1. State goes to IDLE, counters and `tile_idx` go to 0, latched fields clear.
  - In the cycle after reset: `cmd_ready`=1; `busy`, `feed_en`, `acc_en`, `acc_clear`, `load_req`, `out_valid`, `done` = 0; `tile_idx`=0.
- Reset mid-command: the command is discarded with no `done` pulse, and `feed_en` drops at that same edge.
- Cycle numbering: cycle 0 is the accept cycle. For tiles=1, clear=0, `load_ack`=1, `out_ready`=1:
  - LOAD in cycle 1;
  - `feed_en` high in cycles 2..64 (63 cycles);
  - DRAIN in cycles 65..96;
  - `out_valid` in cycle 97;
  - `done` in cycle 98;
  - `cmd_ready` high again in cycle 99.
- `cmd_clear`=1 inserts CLR in cycle 1 and shifts everything after it by +1.
- Between consecutive tiles, `feed_en` is low for at least one cycle (the LOAD cycle). This guarantees the feeder restarts at step 0.
- `acc_en` is low during LOAD gaps.
- Each cycle of `load_ack` or `out_ready` stall adds exactly one cycle.

## Test plan
- Reset then single command (tiles=1, clear=0, `load_ack`/`out_ready` tied high) -> `feed_en` high for exactly 63 cycles (2..64), `out_valid` at cycle 97, `done` at cycle 98, `busy` at 0 in cycle 99.
- tiles=3, clear=1, `load_ack` delayed 4 cycles on each load -> `acc_clear` pulses once in cycle 1, three 63-cycle `feed_en` windows each separated by ≥1 low cycle, `tile_idx` reads 0,1,2, then one 32-cycle drain.
- tiles=0 -> no `load_req`/`feed_en`/`acc_en`/`acc_clear`; `done` in cycle 1; `cmd_ready` in cycle 2.
- `out_ready` held low for 10 cycles in RESULT, with `cmd_valid` held high throughout -> `out_valid` stays high for 11 cycles, `cmd_ready` stays 0 until IDLE, and the second command is accepted exactly one cycle after `done`.
- `rst` asserted at cycle 30 (mid-FEED) -> next cycle `feed_en`=0, `busy`=0, `tile_idx`=0, and no `done`; a new command then executes with full 63-cycle timing.
- tiles=255 -> 255 feed windows, `tile_idx` ends at 254 with no wrap, and a single `done`.
